// File: rtl/video_stream_pkg.sv
// Purpose: shared encodings for the synthetic video source (patterns, stream bit map, FSM states).
// Latency: n/a (constants and a constant function only).
// Backpressure: n/a.
package video_stream_pkg;

    // Pattern select encoding
    localparam logic [1:0] PAT_FLAT  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_CHECK = 2'd3;

    // Bit positions inside the 21-bit pixel stream; data occupies [15:0] as {Y, C}
    localparam int DE_BIT     = 20;
    localparam int HBLANK_BIT = 19;
    localparam int VBLANK_BIT = 18;
    localparam int SPDIF_BIT  = 17;
    localparam int WIN_BIT    = 16;

    localparam logic [7:0] CHROMA_NEUTRAL = 8'h80;
    localparam logic [7:0] LUMA_GREY      = 8'h80;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    // True when max_val is representable in an unsigned counter of the given width
    function automatic bit cnt_fits(input int width, input int max_val);
        return (longint'(max_val) >> width) == 64'd0;
    endfunction

endpackage

// File: rtl/video_timing_counter.sv
// Purpose: h/v raster counters with wrap, terminal-count flags and a frame-wrap pulse.
// Latency: counters update on the clock after advance_i; flags are combinational from the counters.
// Backpressure: none; advance_i=0 holds position, clear_i forces (0,0) and has priority.
// Ports: clk_i, rst_ni (async active-low); advance_i, clear_i; h_o, v_o, h_tc_o, v_tc_o, frame_wrap_o.
module video_timing_counter #(
    parameter int H_TOTAL   = 1650,
    parameter int V_TOTAL   = 750,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 advance_i,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] h_o,
    output logic [CNT_WIDTH-1:0] v_o,
    output logic                 h_tc_o,
    output logic                 v_tc_o,
    output logic                 frame_wrap_o
);

    localparam logic [CNT_WIDTH-1:0] H_LAST = CNT_WIDTH'(H_TOTAL - 1);
    localparam logic [CNT_WIDTH-1:0] V_LAST = CNT_WIDTH'(V_TOTAL - 1);

    logic [CNT_WIDTH-1:0] h_q, h_d;
    logic [CNT_WIDTH-1:0] v_q, v_d;

    assign h_tc_o       = (h_q == H_LAST);
    assign v_tc_o       = (v_q == V_LAST);
    assign frame_wrap_o = advance_i && h_tc_o && v_tc_o;

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (clear_i) begin
            h_d = '0;
            v_d = '0;
        end else if (advance_i) begin
            h_d = h_tc_o ? '0 : h_q + CNT_WIDTH'(1);
            if (h_tc_o) begin
                v_d = v_tc_o ? '0 : v_q + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_o = h_q;
    assign v_o = v_q;

endmodule

// File: rtl/video_stream_pattern_gen.sv
// Purpose: synthetic 21-bit video source (de/Hblank/Vblank/spdif/win + {Y,C}) with programmable timing.
// Latency: outputs registered one cycle after the raster position; first pixel two edges after enable.
// Backpressure: none; enable is a level run request, dropping it lets the current frame finish.
// Ports: clk, reset (async active-low), enable, pattern_sel, win_x0/x1/y0/y1, spdif_in ->
//        de_out, Hblank_out, Vblank_out, spdif_out, win_enable_out, data_out, frame_start.
// Option: PATTERN_GEN_FRAME_SCROLL_EN adds an 8-bit frame counter that scrolls patterns 1-3.
module video_stream_pattern_gen #(
    parameter int H_ACTIVE  = 1280,
    parameter int H_BLANK   = 370,
    parameter int V_ACTIVE  = 720,
    parameter int V_BLANK   = 30,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           pattern_sel,
    input  logic [CNT_WIDTH-1:0] win_x0,
    input  logic [CNT_WIDTH-1:0] win_x1,
    input  logic [CNT_WIDTH-1:0] win_y0,
    input  logic [CNT_WIDTH-1:0] win_y1,
    input  logic                 spdif_in,
    output logic                 de_out,
    output logic                 Hblank_out,
    output logic                 Vblank_out,
    output logic                 spdif_out,
    output logic                 win_enable_out,
    output logic [15:0]          data_out,
    output logic                 frame_start
);
    import video_stream_pkg::*;

    localparam int H_TOTAL = H_ACTIVE + H_BLANK;
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam logic [CNT_WIDTH-1:0] H_ACT_C = CNT_WIDTH'(H_ACTIVE);
    localparam logic [CNT_WIDTH-1:0] V_ACT_C = CNT_WIDTH'(V_ACTIVE);

    generate
        if (!cnt_fits(CNT_WIDTH, H_TOTAL - 1) || !cnt_fits(CNT_WIDTH, V_TOTAL - 1) || CNT_WIDTH < 8) begin : g_width_check
            $error("CNT_WIDTH too narrow for the configured raster");
        end
    endgenerate

    state_e state_q, state_d;
    logic                 active;
    logic [CNT_WIDTH-1:0] h, v;
    logic                 h_tc, v_tc, frame_wrap;

    assign active = (state_q != ST_IDLE);

    video_timing_counter #(
        .H_TOTAL   (H_TOTAL),
        .V_TOTAL   (V_TOTAL),
        .CNT_WIDTH (CNT_WIDTH)
    ) u_timing (
        .clk_i        (clk),
        .rst_ni       (reset),
        .advance_i    (active),
        .clear_i      (!active),
        .h_o          (h),
        .v_o          (v),
        .h_tc_o       (h_tc),
        .v_tc_o       (v_tc),
        .frame_wrap_o (frame_wrap)
    );

    // enable only matters in IDLE and at the frame boundary; RUN/DRAIN just record intent
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (enable) state_d = ST_RUN;
            ST_RUN:   if (!enable) state_d = frame_wrap ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: begin
                if (enable)          state_d = ST_RUN;
                else if (frame_wrap) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Frame-level configuration: the first pixel uses the live inputs, the rest of the frame the capture
    logic                 first_px;
    logic [1:0]           pat_q, pat_d;
    logic [CNT_WIDTH-1:0] wx0_q, wx0_d, wx1_q, wx1_d, wy0_q, wy0_d, wy1_q, wy1_d;

    always_comb begin
        first_px = active && (h == '0) && (v == '0);
        pat_d    = first_px ? pattern_sel : pat_q;
        wx0_d    = first_px ? win_x0 : wx0_q;
        wx1_d    = first_px ? win_x1 : wx1_q;
        wy0_d    = first_px ? win_y0 : wy0_q;
        wy1_d    = first_px ? win_y1 : wy1_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q <= PAT_FLAT;
            wx0_q <= '0;
            wx1_q <= '0;
            wy0_q <= '0;
            wy1_q <= '0;
        end else begin
            pat_q <= pat_d;
            wx0_q <= wx0_d;
            wx1_q <= wx1_d;
            wy0_q <= wy0_d;
            wy1_q <= wy1_d;
        end
    end

    // Horizontal coordinate seen by the pattern generator
    logic [7:0] xh;
`ifdef PATTERN_GEN_FRAME_SCROLL_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!active)         frame_cnt_d = '0;
        else if (frame_wrap) frame_cnt_d = frame_cnt_q + 8'd1;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end
    assign xh = h[7:0] + frame_cnt_q;
`else
    assign xh = h[7:0];
`endif

    logic        de_d, win_d;
    logic [7:0]  y_d;
    logic [20:0] stream_q, stream_d;
    logic        fs_q;

    always_comb begin
        de_d  = active && (h < H_ACT_C) && (v < V_ACT_C);
        win_d = de_d && (h >= wx0_d) && (h <= wx1_d) && (v >= wy0_d) && (v <= wy1_d);
        case (pat_d)
            PAT_RAMP:  y_d = xh;
            PAT_BARS:  y_d = {8{xh[7]}};
            PAT_CHECK: y_d = {8{xh[4] ^ v[4]}};
            default:   y_d = LUMA_GREY;
        endcase
        stream_d             = '0;
        stream_d[DE_BIT]     = de_d;
        stream_d[HBLANK_BIT] = active && (h >= H_ACT_C);
        stream_d[VBLANK_BIT] = active && (v >= V_ACT_C);
        stream_d[SPDIF_BIT]  = active && spdif_in;
        stream_d[WIN_BIT]    = win_d;
        stream_d[15:0]       = de_d ? {y_d, CHROMA_NEUTRAL} : 16'h0000;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stream_q <= '0;
            fs_q     <= 1'b0;
        end else begin
            stream_q <= stream_d;
            fs_q     <= first_px;
        end
    end

    assign de_out         = stream_q[DE_BIT];
    assign Hblank_out     = stream_q[HBLANK_BIT];
    assign Vblank_out     = stream_q[VBLANK_BIT];
    assign spdif_out      = stream_q[SPDIF_BIT];
    assign win_enable_out = stream_q[WIN_BIT];
    assign data_out       = stream_q[15:0];
    assign frame_start    = fs_q;

endmodule
